// File: rtl/hub75_panel_driver.sv
// 64x64 HUB75 driver: two read-first framebuffer RAMs, 1/32 scan with BCM, writes never stalled.
// Define FB_CLEAR_EN to zero the framebuffer (one entry per cycle) after every reset before scanning.
module hub75_panel_driver #(
  parameter int PANEL_INDEX = 0,
  parameter int BASE_TIME   = 8,
  parameter int COLOR_BITS  = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  ctrl_en,
  input  logic [3:0]  ctrl_wr,
  input  logic [15:0] ctrl_addr,
  input  logic [23:0] ctrl_wdat,
  output logic [2:0]  hub75_rgb0,
  output logic [2:0]  hub75_rgb1,
  output logic [4:0]  hub75_addr,
  output logic        hub75_clk,
  output logic        hub75_lat,
  output logic        hub75_oe,
  output logic        frame_start
);
  localparam int W        = 3 * COLOR_BITS;
  localparam int DISP_MAX = BASE_TIME << (COLOR_BITS - 1);
  localparam int DISP_W   = $clog2(DISP_MAX + 1);
  localparam int CNT_W    = (DISP_W > 8) ? DISP_W : 8;

  typedef enum logic [1:0] {S_SHIFT, S_LATCH, S_DISPLAY, S_BLANK} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_row;
  logic [2:0]       r_bit;
  logic [4:0]       r_addr;
  logic             r_show;
  logic [W-1:0]     r_mem_top [0:2047];
  logic [W-1:0]     r_mem_bot [0:2047];
  logic [W-1:0]     r_q_top, r_q_bot;

  logic             w_clr_busy;
  logic [10:0]      w_clr_addr;
  logic             w_scan_rst;
  logic             w_wr_hit;
  logic [10:0]      w_wr_addr;
  logic [10:0]      w_rd_addr;
  logic [2:0]       w_lane_we, w_we_top, w_we_bot;
  logic [W-1:0]     w_wr_data;
  logic             w_shift_last, w_disp_last;
  logic [COLOR_BITS-1:0] w_top_r, w_top_g, w_top_b, w_bot_r, w_bot_g, w_bot_b;
  logic             w_unused;

`ifdef FB_CLEAR_EN
  logic        r_clr_busy;
  logic [10:0] r_clr_addr;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_clr_busy <= 1'b1;
      r_clr_addr <= '0;
    end else if (r_clr_busy) begin
      r_clr_addr <= r_clr_addr + 11'd1;
      if (r_clr_addr == 11'h7FF) r_clr_busy <= 1'b0;
    end
  end

  assign w_clr_busy = r_clr_busy;
  assign w_clr_addr = r_clr_addr;
`else
  assign w_clr_busy = 1'b0;
  assign w_clr_addr = '0;
`endif

  assign w_scan_rst = reset | w_clr_busy;

  // The clear walk borrows the write port and writes both halves at once.
  assign w_wr_hit  = ctrl_en[PANEL_INDEX] && (ctrl_addr[15:12] == 4'd0) && !w_clr_busy;
  assign w_wr_addr = w_clr_busy ? w_clr_addr : ctrl_addr[10:0];
  assign w_lane_we = w_clr_busy ? 3'b111 : (w_wr_hit ? ctrl_wr[2:0] : 3'b000);
  assign w_we_top  = w_lane_we & {3{w_clr_busy | ~ctrl_addr[11]}};
  assign w_we_bot  = w_lane_we & {3{w_clr_busy |  ctrl_addr[11]}};
  assign w_wr_data = w_clr_busy ? '0 :
                     {ctrl_wdat[16 +: COLOR_BITS], ctrl_wdat[8 +: COLOR_BITS], ctrl_wdat[0 +: COLOR_BITS]};
  assign w_rd_addr = {r_row, r_cnt[6:1]};

  always_ff @(posedge clock) begin
    for (int l = 0; l < 3; l++) begin
      if (w_we_top[l]) r_mem_top[w_wr_addr][l*COLOR_BITS +: COLOR_BITS] <= w_wr_data[l*COLOR_BITS +: COLOR_BITS];
      if (w_we_bot[l]) r_mem_bot[w_wr_addr][l*COLOR_BITS +: COLOR_BITS] <= w_wr_data[l*COLOR_BITS +: COLOR_BITS];
    end
    r_q_top <= r_mem_top[w_rd_addr];
    r_q_bot <= r_mem_bot[w_rd_addr];
  end

  assign w_shift_last = (r_cnt == CNT_W'(128));
  assign w_disp_last  = (r_cnt == CNT_W'((BASE_TIME << r_bit) - 1));

  always_ff @(posedge clock) begin
    if (w_scan_rst) r_state <= S_SHIFT;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    hub75_clk   = 1'b0;
    hub75_lat   = 1'b0;
    hub75_oe    = 1'b1;
    frame_start = 1'b0;
    case (r_state)
      S_SHIFT: begin
        hub75_clk   = !r_cnt[0] && (r_cnt != '0);
        frame_start = (r_cnt == '0) && (r_row == 5'd0) && (r_bit == 3'd0) && !reset && !w_clr_busy;
        if (w_shift_last) w_state_nxt = S_LATCH;
      end
      S_LATCH: begin
        hub75_lat   = 1'b1;
        w_state_nxt = S_DISPLAY;
      end
      S_DISPLAY: begin
        hub75_oe = 1'b0;
        if (w_disp_last) w_state_nxt = S_BLANK;
      end
      S_BLANK:  w_state_nxt = S_SHIFT;
      default:  w_state_nxt = S_SHIFT;
    endcase
  end

  // r_cnt is the column phase counter in S_SHIFT and the on-time counter in S_DISPLAY.
  always_ff @(posedge clock) begin
    if (w_scan_rst) begin
      r_cnt  <= '0;
      r_row  <= '0;
      r_bit  <= '0;
      r_addr <= '0;
      r_show <= 1'b0;
    end else begin
      case (r_state)
        S_SHIFT: begin
          if (!r_cnt[0]) r_show <= 1'b1;
          if (w_shift_last) begin
            r_cnt  <= '0;
            r_addr <= r_row;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DISPLAY: r_cnt <= w_disp_last ? '0 : r_cnt + 1'b1;
        S_BLANK: begin
          r_cnt <= '0;
          if (r_bit == 3'(COLOR_BITS - 1)) begin
            r_bit <= '0;
            r_row <= r_row + 5'd1;
          end else begin
            r_bit <= r_bit + 3'd1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign w_top_r = r_q_top[2*COLOR_BITS +: COLOR_BITS];
  assign w_top_g = r_q_top[COLOR_BITS +: COLOR_BITS];
  assign w_top_b = r_q_top[0 +: COLOR_BITS];
  assign w_bot_r = r_q_bot[2*COLOR_BITS +: COLOR_BITS];
  assign w_bot_g = r_q_bot[COLOR_BITS +: COLOR_BITS];
  assign w_bot_b = r_q_bot[0 +: COLOR_BITS];

  assign hub75_rgb0 = r_show ? {w_top_r[r_bit], w_top_g[r_bit], w_top_b[r_bit]} : 3'b000;
  assign hub75_rgb1 = r_show ? {w_bot_r[r_bit], w_bot_g[r_bit], w_bot_b[r_bit]} : 3'b000;
  assign hub75_addr = r_addr;

  assign w_unused = &{1'b0, ctrl_en, ctrl_wr[3], ctrl_wdat, w_clr_addr};
endmodule

// File: tb/tb_hub75_panel_driver.sv
// Scoreboarded bench for hub75_panel_driver: a pixel-array model predicts every scan pass.
module tb_hub75_panel_driver;
  localparam int PI = 2;
  localparam int BT = 8;
  localparam int CB = 6;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  ctrl_en = '0;
  logic [3:0]  ctrl_wr = '0;
  logic [15:0] ctrl_addr = '0;
  logic [23:0] ctrl_wdat = '0;
  logic [2:0]  hub75_rgb0, hub75_rgb1;
  logic [4:0]  hub75_addr;
  logic        hub75_clk, hub75_lat, hub75_oe, frame_start;

  hub75_panel_driver #(.PANEL_INDEX(PI), .BASE_TIME(BT), .COLOR_BITS(CB)) dut (
    .clock(clock), .reset(reset), .ctrl_en(ctrl_en), .ctrl_wr(ctrl_wr),
    .ctrl_addr(ctrl_addr), .ctrl_wdat(ctrl_wdat), .hub75_rgb0(hub75_rgb0),
    .hub75_rgb1(hub75_rgb1), .hub75_addr(hub75_addr), .hub75_clk(hub75_clk),
    .hub75_lat(hub75_lat), .hub75_oe(hub75_oe), .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  typedef struct {
    int           row;
    int           bitn;
    logic [191:0] rgb0;
    logic [191:0] rgb1;
    int           oe_len;
  } pass_t;

  pass_t exp_q[$];
  int    per_q[$];
  int    checks = 0;
  int    errors = 0;
  int    pr[4096], pg[4096], pb[4096];

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Pixel (x,y) lives at index y*64+x; bit b of a channel is (value >> b) & 1.
  function automatic pass_t make_pass(input int r, input int b);
    pass_t p;
    int top, bot;
    p.row = r; p.bitn = b; p.oe_len = BT << b;
    p.rgb0 = '0; p.rgb1 = '0;
    for (int c = 0; c < 64; c++) begin
      top = r * 64 + c;
      bot = (r + 32) * 64 + c;
      p.rgb0[c*3+2] = ((pr[top] >> b) & 1) != 0;
      p.rgb0[c*3+1] = ((pg[top] >> b) & 1) != 0;
      p.rgb0[c*3+0] = ((pb[top] >> b) & 1) != 0;
      p.rgb1[c*3+2] = ((pr[bot] >> b) & 1) != 0;
      p.rgb1[c*3+1] = ((pg[bot] >> b) & 1) != 0;
      p.rgb1[c*3+0] = ((pb[bot] >> b) & 1) != 0;
    end
    return p;
  endfunction

  // Cycle offset (from the first scan cycle) at which pass (r,b) starts shifting.
  function automatic int pass_off(input int r, input int b);
    int t;
    t = 0;
    for (int k = 0; k < CB; k++) t += 131 + (BT << k);
    t = t * r;
    for (int k = 0; k < b; k++) t += 131 + (BT << k);
    return t;
  endfunction

  task automatic wr(input logic [5:0] en, input logic [3:0] wl, input logic [15:0] a, input logic [23:0] d);
    int idx;
    ctrl_en = en; ctrl_wr = wl; ctrl_addr = a; ctrl_wdat = d;
    @(posedge clock);
    #1;
    ctrl_en = '0;
    if (en[PI] && a[15:12] == 4'd0) begin
      idx = int'(a[11:0]);
      if (wl[2]) pr[idx] = int'(d[23:16]) % 64;
      if (wl[1]) pg[idx] = int'(d[15:8]) % 64;
      if (wl[0]) pb[idx] = int'(d[7:0]) % 64;
    end
  endtask

  task automatic check_idle(input string tag, input logic fs_exp);
    check({tag, "_oe"},   192'(hub75_oe),    192'(1));
    check({tag, "_lat"},  192'(hub75_lat),   192'(0));
    check({tag, "_clk"},  192'(hub75_clk),   192'(0));
    check({tag, "_addr"}, 192'(hub75_addr),  192'(0));
    check({tag, "_rgb0"}, 192'(hub75_rgb0),  192'(0));
    check({tag, "_rgb1"}, 192'(hub75_rgb1),  192'(0));
    check({tag, "_fs"},   192'(frame_start), 192'(fs_exp));
  endtask

  // Monitor: collects shifted columns, pops one expected pass per latch pulse.
  int           ncol = 0, oe_cnt = 0, cur_oe = 0, fs_cyc = 0, cyc = 0;
  bit           have_pass = 0, fs_seen = 0;
  logic [191:0] sh0 = '0, sh1 = '0;
  pass_t        rec;

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      ncol = 0; oe_cnt = 0; have_pass = 0; fs_seen = 0;
    end else begin
      if (hub75_clk) begin
        if (ncol < 64) begin
          sh0[ncol*3 +: 3] = hub75_rgb0;
          sh1[ncol*3 +: 3] = hub75_rgb1;
        end
        ncol++;
      end
      if (hub75_lat) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL latch unexpected at cycle %0d addr=%0d", cyc, hub75_addr);
        end else begin
          rec = exp_q.pop_front();
          check($sformatf("clk_edges_r%0d_b%0d", rec.row, rec.bitn), 192'(ncol), 192'(64));
          check($sformatf("addr_r%0d_b%0d", rec.row, rec.bitn), 192'(hub75_addr), 192'(rec.row));
          check($sformatf("rgb0_r%0d_b%0d", rec.row, rec.bitn), sh0, rec.rgb0);
          check($sformatf("rgb1_r%0d_b%0d", rec.row, rec.bitn), sh1, rec.rgb1);
          cur_oe = rec.oe_len;
          have_pass = 1;
        end
        ncol = 0;
      end
      if (!hub75_oe) begin
        oe_cnt++;
      end else if (oe_cnt != 0) begin
        if (have_pass) check("oe_low_len", 192'(oe_cnt), 192'(cur_oe));
        oe_cnt = 0;
      end
      if (frame_start) begin
        if (fs_seen) begin
          if (per_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL frame_start unexpected pulse at cycle %0d", cyc);
          end else begin
            check("frame_period", 192'(cyc - fs_cyc), 192'(per_q.pop_front()));
          end
        end
        fs_seen = 1;
        fs_cyc = cyc;
      end
    end
  end

  initial begin
    int x;
    logic [3:0]  hi;
    logic [5:0]  en;
    for (int i = 0; i < 4096; i++) begin pr[i] = 0; pg[i] = 0; pb[i] = 0; end

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_idle("reset", 1'b0);
    @(posedge clock);
    #1;

    // Fill the whole framebuffer, then directed and random writes, all while the scan is held.
    for (int i = 0; i < 4096; i++) wr(6'b000100, 4'b0111, 16'(i), 24'($urandom));
    wr(6'b000100, 4'b0111, 16'h0000, 24'h3F_00_01);
    wr(6'b000001, 4'b0111, 16'h0840, 24'h3F_3F_3F);
    wr(6'b000100, 4'b0111, 16'h0840, 24'h15_0A_2B);
    wr(6'b000100, 4'b0111, 16'h1005, 24'hFF_FF_FF);
    wr(6'b000100, 4'b0111, 16'h0005, 24'h05_11_07);
    wr(6'b000100, 4'b0010, 16'h0005, 24'hFF_2A_FF);
    for (int i = 0; i < 400; i++) begin
      hi = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      en = 6'($urandom);
      if ($urandom_range(0, 1) == 1) en[PI] = 1'b1;
      wr(en, 4'($urandom), {hi, 12'($urandom)}, 24'($urandom));
    end

    for (int r = 0; r < 7; r++)
      for (int b = 0; b < CB; b++) exp_q.push_back(make_pass(r, b));
    for (int b = 0; b < 3; b++) exp_q.push_back(make_pass(7, b));

    reset = 1'b0;
    x = pass_off(7, 2) + 130 + 10;
    repeat (x) @(posedge clock);
    #1;
    reset = 1'b1;
    check("queue_drained_before_reset", 192'(exp_q.size()), 192'(0));
    for (int r = 0; r < 32; r++)
      for (int b = 0; b < CB; b++) exp_q.push_back(make_pass(r, b));
    per_q.push_back(32 * pass_off(1, 0));
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check_idle("after_reset", 1'b1);

    repeat (32 * pass_off(1, 0) + 20) @(posedge clock);
    #1;
    check("queue_drained_end", 192'(exp_q.size()), 192'(0));
    check("period_drained_end", 192'(per_q.size()), 192'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hub75_panel_driver.md
Name: hub75_panel_driver

Overview:
- Consumes the per-panel pixel write bus (ctrl_en/ctrl_wr/ctrl_addr/ctrl_wdat) produced by the UDP panel writer.
- Stores pixels for one 64x64 HUB75 panel in an internal framebuffer.
- Continuously scans the framebuffer out to the panel using 1/32 scan and binary-coded modulation (BCM) of the 6-bit colour channels.
- One instance per panel; PANEL_INDEX selects which ctrl_en bit it responds to.

Parameters:
- PANEL_INDEX, 0, ctrl_en bit this instance accepts writes on (0..5).
- BASE_TIME, 8, OE-low clock cycles for BCM bit 0; bit b lasts BASE_TIME<<b cycles.
- COLOR_BITS, 6, bits per colour channel stored and modulated.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- ctrl_en  in  6  per-panel write strobe, one-cycle pulse
- ctrl_wr  in  4  lane enables: bit2=R, bit1=G, bit0=B, bit3 ignored
- ctrl_addr  in  16  pixel address, y*64+x
- ctrl_wdat  in  24  R in [23:16], G in [15:8], B in [7:0]; only low COLOR_BITS of each lane used
- hub75_rgb0  out  3  {r,g,b} for the top half, rows 0..31
- hub75_rgb1  out  3  {r,g,b} for the bottom half, rows 32..63
- hub75_addr  out  5  scan row
- hub75_clk  out  1  shift clock
- hub75_lat  out  1  latch
- hub75_oe  out  1  output enable, active-low (1 = blank)
- frame_start  out  1  one-cycle pulse at start of row 0, bit 0

Behaviour:

Reset values:
- hub75_oe=1; all other outputs 0.
- FSM in S_SHIFT with row=0, bit=0, col=0.

Framebuffer:
- Two RAMs (top, bottom), each 2048 x (3*COLOR_BITS).
- ctrl_addr[11] selects the RAM; ctrl_addr[10:0] is the entry.

Write path:
- A write occurs in the cycle ctrl_en[PANEL_INDEX]=1.
- Only lanes with their ctrl_wr bit set are updated; other channels keep their value (per-channel write enable).
- If ctrl_addr[15:12] != 0, the write is dropped.
- ctrl_en bits other than PANEL_INDEX are ignored.
- Writes are never back-pressured; every qualifying strobe is taken.

Read/write collision:
- Same entry read and written in the same cycle: the read returns old data (read-first). The new value appears from the next scan onward.

Scan FSM:
- S_SHIFT: for col 0..63, each column takes 2 cycles.
  - Cycle A: issue read of entry {row,col} to both RAMs. hub75_clk=0.
  - Cycle B: RAM data valid (1-cycle read latency). Drive hub75_rgb0/1 = bit[bit] of each channel; hub75_clk=0.
  - hub75_clk=1 in cycle A of the next column. After col 63, one extra cycle with hub75_clk=1.
  - hub75_oe=1 throughout.
  - 129 cycles total, then go to S_LATCH.
- S_LATCH: hub75_lat=1 for one cycle; hub75_addr updates to row in the same cycle. Go to S_DISPLAY.
- S_DISPLAY: hub75_oe=0 for exactly BASE_TIME<<bit cycles, then go to S_BLANK.
- S_BLANK: hub75_oe=1 for one cycle, then advance and return to S_SHIFT.
  - If bit < COLOR_BITS-1: bit+1.
  - Otherwise: bit=0 and row+1, with row wrapping 31->0.
- frame_start pulses in the first S_SHIFT cycle of row 0, bit 0, including the first cycle after reset release.

Frame period (defaults):
- Per row: 6*(129+1+1) + 8*63 = 786+504 = 1290 cycles.
- Per frame: 32*1290 = 41280 cycles.

Counter widths:
- col 6 bits, row 5 bits, bit 3 bits.
- Display counter wide enough for BASE_TIME<<(COLOR_BITS-1).

Reset mid-operation:
- Scan aborts immediately and outputs return to reset values.
- Framebuffer contents are retained (unless FB_CLEAR_EN is defined).

Optional Feature:

FB_CLEAR_EN:
- Defined: on reset deassertion, the block walks entries 0..2047 writing zero to both RAMs, one entry per cycle (2048 cycles).
  - During the clear: ctrl bus writes are dropped, the scan FSM is held in reset state (oe=1), and frame_start stays 0.
  - The scan starts the cycle after the clear completes.
  - Reset during the clear restarts it from entry 0.
- Undefined: no clear. RAM initialises to zero at configuration only, and the scan starts the first cycle after reset.

Test Plan:
1. PANEL_INDEX=2; write ctrl_en=6'b000100, ctrl_wr=4'b0111, addr=16'h0000, wdat=24'h3F_00_01.
   -> During row 0, col 0: rgb0={1,0,1} in bit 0, rgb0={1,0,0} in bits 1..5; rgb1=0.
2. Write addr=16'h0840 (x=0, y=33) with ctrl_en=6'b000001 on an instance with PANEL_INDEX=2.
   -> No change. Same write with ctrl_en=6'b000100 -> appears on rgb1 at row 1, col 0.
3. Write addr=16'h1005 -> dropped. Then ctrl_wr=4'b0010, wdat=24'hFF_2A_FF to a pixel holding R=5, B=7.
   -> Pixel reads R=5, G=0x2A, B=7.
4. Timing: BASE_TIME=8.
   -> hub75_oe low 8, 16, 32, 64, 128, 256 cycles in successive bits.
   -> Exactly 64 rising hub75_clk edges before each lat pulse.
   -> frame_start period 41280 cycles.
   -> hub75_addr increments once per 6 latches and wraps 31->0.
5. Assert reset for 1 cycle during S_DISPLAY of row 7.
   -> Next cycle oe=1, addr=0, frame_start pulses after release; pixels written earlier are still displayed.
6. FB_CLEAR_EN defined: preload pixels, reset.
   -> 2048 cycles with oe=1 and writes ignored; afterwards all pixels scan as zero; frame_start first pulses at cycle 2049.
